irda_transmit: RTL and testbench
================================

Name: irda_transmit

Overview:
- IrDA SIR (RZI) transmitter for the TFDU4101 transceiver on the icestick board.
- Accepts bytes on the same stb/dat/rdy handshake as the UART transmit block.
- Encodes 8N1 frames as 3/16-bit-width optical pulses on irda_txd and optionally manages the transceiver shutdown pin.
- Completes the IrDA path opposite the board's irda_rxd input.

Parameters:
- BAUD, 9600: bit rate in bits/s.
- FREQ, 12000000: clk frequency in Hz.
- SHUTDOWN, 64: idle bit periods before irda_sd asserts (used only with the macro).
- WAKE, 4: bit periods between irda_sd release and the start pulse (used only with the macro).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk.
- stb  input  1  byte valid.
- dat  input  8  byte to send; sampled when stb && rdy at a rising edge.
- rdy  output 1  ready to accept a byte.
- txd  output 1  IrDA LED drive; 1 = pulse/LED on.
- sd   output 1  transceiver shutdown; 1 = shutdown.

Behaviour:
- Derived constants:
  - DIV = FREQ/BAUD, integer division. DIV must be at least 16; if it is not, an elaboration error is raised.
  - PULSE = (3*DIV)/16, integer division.
- Frame format: start bit 0, then dat[0]..dat[7], then stop bit 1. Each bit lasts DIV clk cycles.
- Encoding:
  - A 0 bit sets txd=1 for the first PULSE cycles of the bit slot, then txd=0 for the remaining DIV-PULSE cycles.
  - A 1 bit keeps txd=0 for the whole slot.
  - txd is a flop output and must be glitch-free.
- State machine: IDLE, WAKE (only with the macro), START, DATA, STOP.
  - IDLE: rdy=1. On stb&&rdy, latch dat into the shift register, clear the cycle counter, and go to START. With the macro and sd=1, go to WAKE instead.
  - WAKE: sd=0, txd=0 for WAKE*DIV cycles, then START.
  - START: lasts DIV cycles, then DATA with the bit index at 0.
  - DATA: shift out LSB first; after the 8th bit's DIV cycles, go to STOP.
  - STOP: lasts DIV cycles. During the last STOP cycle rdy=1. If stb is high then, accept the byte and go directly to START; otherwise go to IDLE.
- rdy=0 in every other cycle of WAKE, START, DATA and STOP.
- Latency: if a byte is accepted at edge E, txd=1 from E to E+PULSE, and the frame occupies exactly 10*DIV cycles.
- Back-to-back frames: start pulses are exactly 10*DIV cycles apart, with no idle gap.
- Changes to dat or stb while rdy=0 are ignored; the latched byte is transmitted unchanged.
- Reset values: state IDLE, txd=0, rdy=1, counters 0, sd=0.
  - stb is ignored in any cycle where rst=0.
  - Reset mid-frame aborts the frame at the next edge: txd=0, with no partial pulse continuation.
- Counter widths: $clog2(DIV) for the cycle counter and 3 bits for the bit index. Both wrap to 0 at the terminal count and never overflow.

Optional Feature:
- Macro: IRDA_SHUTDOWN_EN.
- With the macro defined:
  - An idle counter counts cycles in IDLE. sd goes to 1 on the edge where the count reaches SHUTDOWN*DIV, and the counter saturates there.
  - An accepted byte clears the counter.
  - If the byte is accepted while sd=1, sd drops to 0 on the accepting edge and the frame passes through WAKE first.
  - Any reset sets sd=0 and the counter to 0.
- Without the macro: sd is constant 0, the WAKE state and the idle counter are absent, and the SHUTDOWN and WAKE parameters are unused.

Test Plan (BAUD=1000000, FREQ=16000000 → DIV=16, PULSE=3):
- Reset: rst=0 for 5 cycles with stb=1, dat=0x00 → txd stays 0, no frame starts, rdy=1, sd=0.
- Send 0x55 → 3-cycle txd pulses start at cycles 0, 32, 64, 96 and 128 after acceptance (start bit and bits 1, 3, 5, 7); no other txd activity; rdy=0 for cycles 0..158 and 1 at cycle 159.
- Send 0x00 → 9 pulses, 16 cycles apart. Send 0xFF → only the start pulse, then txd=0 for 157 cycles.
- stb held high with 0xA5 then 0x3C → second start pulse exactly 160 cycles after the first; decoded bits match both bytes.
- rst=0 asserted at cycle 50 of a 0x00 frame → txd=0 and rdy=1 after that edge; the next byte sent after reset produces a clean, full frame.
- IRDA_SHUTDOWN_EN, SHUTDOWN=4, WAKE=2 → sd=1 after 64 idle cycles. Then send 0x0F → sd=0 on the accepting edge and the start pulse begins 32 cycles later.

Source files
------------

// File: rtl/irda_transmit.sv
// IrDA SIR (RZI) transmitter: 8N1 frames sent as 3/16-bit-width pulses on txd.
// Define IRDA_SHUTDOWN_EN to assert the transceiver shutdown pin after an idle period.
module irda_transmit #(
   parameter int BAUD     = 9600,
   parameter int FREQ     = 12000000,
   parameter int SHUTDOWN = 64,
   parameter int WAKE     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stb,
   input  logic [7:0] dat,
   output logic       rdy,
   output logic       txd,
   output logic       sd
);
   localparam int DIV   = FREQ / BAUD;
   localparam int PULSE = (3 * DIV) / 16;
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE);

   if (DIV < 16 || SHUTDOWN < 1 || WAKE < 1) begin : g_param_check
      $error("irda_transmit: FREQ/BAUD must be at least 16, SHUTDOWN and WAKE positive");
   end

`ifdef IRDA_SHUTDOWN_EN
   typedef enum logic [2:0] {S_IDLE, S_WAKE, S_START, S_DATA, S_STOP} state_t;

   localparam int IDLE_MAX = ((SHUTDOWN > WAKE) ? SHUTDOWN : WAKE) * DIV;
   localparam int IDLE_W   = $clog2(IDLE_MAX + 1);
   localparam logic [IDLE_W-1:0] SD_CNT  = IDLE_W'(SHUTDOWN * DIV);
   localparam logic [IDLE_W-1:0] WK_LAST = IDLE_W'(WAKE * DIV - 1);

   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              sd_q, sd_d;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       sh_q, sh_d;
   logic             txd_q, txd_d;

   // A zero bit lights the LED for the first PULSE cycles of its slot; the start bit is always zero.
   function automatic logic pulse_on(input state_t st, input logic [CNT_W-1:0] c, input logic b);
      return ((st == S_START) || (st == S_DATA && !b)) && (c < PULSE_END);
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      sh_d    = sh_q;
      rdy     = 1'b0;
`ifdef IRDA_SHUTDOWN_EN
      idle_d  = idle_q;
      sd_d    = sd_q;
`endif
      case (state_q)
         S_IDLE: begin
            rdy   = 1'b1;
            cnt_d = '0;
            if (stb) begin
               sh_d    = dat;
               idx_d   = '0;
               state_d = S_START;
            end
`ifdef IRDA_SHUTDOWN_EN
            if (stb) begin
               idle_d = '0;
               if (sd_q) begin
                  state_d = S_WAKE;
                  sd_d    = 1'b0;
               end
            end else if (idle_q != SD_CNT) begin
               idle_d = idle_q + 1'b1;
               if (idle_d == SD_CNT) sd_d = 1'b1;
            end
`endif
         end
`ifdef IRDA_SHUTDOWN_EN
         // The idle counter doubles as the wake-up timer; it is always zero on entry.
         S_WAKE: begin
            cnt_d = '0;
            if (idle_q == WK_LAST) begin
               idle_d  = '0;
               state_d = S_START;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
`endif
         S_START: begin
            if (cnt_q == CNT_LAST) begin
               idx_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               sh_d  = {1'b0, sh_q[7:1]};
               idx_d = idx_q + 1'b1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_LAST) begin
               rdy = 1'b1;
               if (stb) begin
                  sh_d    = dat;
                  idx_d   = '0;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      txd_d = pulse_on(state_d, cnt_d, sh_d[0]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         txd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         txd_q   <= txd_d;
      end
      sh_q <= sh_d;
   end

`ifdef IRDA_SHUTDOWN_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         idle_q <= '0;
         sd_q   <= 1'b0;
      end else begin
         idle_q <= idle_d;
         sd_q   <= sd_d;
      end
   end

   assign sd = sd_q;
`else
   assign sd = 1'b0;
`endif

   assign txd = txd_q;

endmodule

// File: tb/tb_irda_transmit.sv
// Directed bench for irda_transmit at DIV=16 (PULSE=3); define IRDA_SHUTDOWN_EN
// to also exercise the shutdown/wake sequence with SHUTDOWN=4, WAKE=2.
module tb_irda_transmit;
   localparam int BAUD = 1000000;
   localparam int FREQ = 16000000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       stb = 1'b0;
   logic [7:0] dat = 8'h00;
   logic       rdy, txd, sd;

   int n_assert = 0;
   int n_fail   = 0;

   logic txw [0:399];
   logic rdw [0:399];
   logic sdw [0:399];

`ifdef IRDA_SHUTDOWN_EN
   irda_transmit #(.BAUD(BAUD), .FREQ(FREQ), .SHUTDOWN(4), .WAKE(2)) dut (
      .clk(clk), .rst(rst), .stb(stb), .dat(dat), .rdy(rdy), .txd(txd), .sd(sd));
`else
   irda_transmit #(.BAUD(BAUD), .FREQ(FREQ)) dut (
      .clk(clk), .rst(rst), .stb(stb), .dat(dat), .rdy(rdy), .txd(txd), .sd(sd));
`endif

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   // Present a byte while idle; it is taken on the next rising edge, after which dat is scrambled.
   task automatic send_start(input logic [7:0] b);
      stb = 1'b1;
      dat = b;
      @(posedge clk);
      #1;
      stb = 1'b0;
      dat = ~b;
   endtask

   task automatic capture(input int n, input int drop_at);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         txw[k] = txd;
         rdw[k] = rdy;
         sdw[k] = sd;
         if (k == drop_at) stb = 1'b0;
      end
   endtask

   task automatic check_frames(input string tag, input int off, input logic [7:0] b0,
                               input logic [7:0] b1, input int nfr, input int exp_pulses);
      int         bad, pulses, slot;
      logic [7:0] byt, dec;
      logic       bv, et, er;
      bad    = 0;
      pulses = 0;
      for (int k = 0; k < nfr * 160; k++) begin
         byt  = (k < 160) ? b0 : b1;
         slot = (k % 160) / 16;
         if (slot == 0)      bv = 1'b0;
         else if (slot == 9) bv = 1'b1;
         else                bv = byt[slot-1];
         et = !bv && ((k % 16) < 3);
         er = ((k % 160) == 159);
         if (txw[off+k] !== et || rdw[off+k] !== er || sdw[off+k] !== 1'b0) bad++;
         if (txw[off+k] === 1'b1 && (k == 0 || txw[off+k-1] !== 1'b1)) pulses++;
      end
      chk({tag, " waveform errors"}, bad, 0);
      chk({tag, " pulse count"}, pulses, exp_pulses);
      for (int f = 0; f < nfr; f++) begin
         for (int b = 0; b < 8; b++) dec[b] = ~txw[off + f*160 + (b+1)*16];
         chk({tag, " decoded byte"}, dec, (f == 0) ? b0 : b1);
      end
      chk({tag, " idle txd"}, txw[off + nfr*160], 1'b0);
      chk({tag, " idle rdy"}, rdw[off + nfr*160], 1'b1);
   endtask

   initial begin
      // Reset held with stb asserted: nothing may start.
      rst = 1'b0;
      stb = 1'b1;
      dat = 8'h00;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("reset txd", txd, 1'b0);
         chk("reset rdy", rdy, 1'b1);
         chk("reset sd", sd, 1'b0);
      end
      stb = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("idle txd", txd, 1'b0);
      chk("idle rdy", rdy, 1'b1);

      send_start(8'h55);
      capture(161, -1);
      chk("0x55 pulse at 32", txw[32], 1'b1);
      chk("0x55 quiet at 16", txw[16], 1'b0);
      chk("0x55 rdy at 158", rdw[158], 1'b0);
      check_frames("0x55", 0, 8'h55, 8'h00, 1, 5);

      send_start(8'h00);
      capture(161, -1);
      check_frames("0x00", 0, 8'h00, 8'h00, 1, 9);

      send_start(8'hFF);
      capture(161, -1);
      chk("0xFF pulse end", txw[3], 1'b0);
      check_frames("0xFF", 0, 8'hFF, 8'h00, 1, 1);

      // Back-to-back: stb stays high, dat changes while busy.
      stb = 1'b1;
      dat = 8'hA5;
      @(posedge clk);
      #1;
      dat = 8'h3C;
      capture(321, 160);
      chk("b2b gap before second", txw[159], 1'b0);
      chk("b2b second start", txw[160], 1'b1);
      check_frames("b2b", 0, 8'hA5, 8'h3C, 2, 10);

      // Reset in the middle of a pulse.
      send_start(8'h00);
      capture(51, -1);
      chk("midreset pulse live", txw[50], 1'b1);
      rst = 1'b0;
      stb = 1'b1;
      dat = 8'hFF;
      @(negedge clk);
      chk("midreset txd", txd, 1'b0);
      chk("midreset rdy", rdy, 1'b1);
      rst = 1'b1;
      stb = 1'b0;
      @(negedge clk);
      chk("after reset txd", txd, 1'b0);
      chk("after reset rdy", rdy, 1'b1);
      send_start(8'h00);
      capture(161, -1);
      check_frames("post-reset", 0, 8'h00, 8'h00, 1, 9);

`ifdef IRDA_SHUTDOWN_EN
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (63) @(negedge clk);
      chk("sd before 64", sd, 1'b0);
      @(negedge clk);
      chk("sd at 64", sd, 1'b1);
      chk("sd idle rdy", rdy, 1'b1);
      send_start(8'h0F);
      capture(193, -1);
      chk("wake sd drop", sdw[0], 1'b0);
      begin
         int bad;
         bad = 0;
         for (int k = 0; k < 32; k++) if (txw[k] !== 1'b0 || rdw[k] !== 1'b0 || sdw[k] !== 1'b0) bad++;
         chk("wake window errors", bad, 0);
      end
      chk("wake start pulse", txw[32], 1'b1);
      check_frames("wake 0x0F", 32, 8'h0F, 8'h00, 1, 5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
